// File: rtl/burst_ram.sv
// burst_ram: block-RAM stand-in for the PSRAM HS IP with calibration delay,
// fixed-latency 4-beat read bursts and 4-beat write bursts.
module burst_ram #(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int BURST_COUNT = 4,
    parameter int CYCLES_BEFORE_DATA_VALID = 6,
    parameter int CYCLES_BEFORE_INITIATED = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd,
    input  logic                      cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0] addr,
    input  logic [63:0]               wr_data,
    input  logic [7:0]                data_mask,
    output logic [63:0]               rd_data,
    output logic                      rd_data_valid,
    output logic                      init_calib,
    output logic                      busy
);
    localparam int DW = DEPTH_BITWIDTH;
    localparam int N = CYCLES_BEFORE_INITIATED;
    localparam int L = CYCLES_BEFORE_DATA_VALID;
    localparam int CW = $clog2(((N > L) ? N : L) + 1);
    localparam logic [2:0] LAST_BEAT = 3'(BURST_COUNT);
    typedef enum logic [2:0] {INIT, IDLE, READ_WAIT, READ_BURST, WRITE_BURST} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [DW-1:0] baddr, baddr_n, waddr;
    logic [2:0] beat, beat_n;
    logic valid_n, calib_n, busy_n, we, re;
    logic [63:0] mem [2**DW];
    logic unused_mask;
    assign unused_mask = ^data_mask;
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        baddr_n = baddr;
        beat_n = beat;
        valid_n = rd_data_valid;
        calib_n = init_calib;
        busy_n = busy;
        we = 1'b0;
        re = 1'b0;
        waddr = baddr;
        case (state)
            INIT: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_n = IDLE;
                    calib_n = 1'b1;
                    busy_n = 1'b0;
                end
            end
            IDLE: if (cmd_en) begin
                busy_n = 1'b1;
                if (cmd) begin
                    we = 1'b1;
                    waddr = addr;
                    baddr_n = addr + DW'(1);
                    beat_n = 3'd1;
                    state_n = WRITE_BURST;
                end else begin
                    baddr_n = addr;
                    cnt_n = CW'(L - 1);
                    state_n = READ_WAIT;
                end
            end
            // leave one edge early so beat 0 lands exactly on edge A+L
            READ_WAIT: begin
                cnt_n = cnt - CW'(1);
                beat_n = 3'd0;
                if (cnt == CW'(1)) state_n = READ_BURST;
            end
            READ_BURST: begin
                if (beat == LAST_BEAT) begin
                    valid_n = 1'b0;
                    busy_n = 1'b0;
                    state_n = IDLE;
                end else begin
                    re = 1'b1;
                    valid_n = 1'b1;
                    baddr_n = baddr + DW'(1);
                    beat_n = beat + 3'd1;
                end
            end
            WRITE_BURST: begin
                we = 1'b1;
                baddr_n = baddr + DW'(1);
                beat_n = beat + 3'd1;
                if (beat == LAST_BEAT - 3'd1) begin
                    busy_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = INIT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt <= CW'(N);
            baddr <= '0;
            beat <= '0;
            rd_data_valid <= 1'b0;
            init_calib <= 1'b0;
            busy <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            baddr <= baddr_n;
            beat <= beat_n;
            rd_data_valid <= valid_n;
            init_calib <= calib_n;
            busy <= busy_n;
        end
    end
    // RAM contents survive reset; only the write in progress at the reset edge is dropped
    always_ff @(posedge clk) begin
        if (we && !rst) mem[waddr] <= wr_data;
    end
    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else if (re) rd_data <= mem[baddr];
    end
endmodule

// File: tb/tb_burst_ram.sv
// tb_burst_ram: directed plus randomized bursts checked against an array model of the RAM.
module tb_burst_ram;
    localparam int DW = 4;
    localparam int D = 16;
    localparam int N = 10;
    localparam int L = 6;
    logic clk = 0, rst = 1, cmd = 0, cmd_en = 0;
    logic [DW-1:0] addr = '0;
    logic [63:0] wr_data = '0;
    logic [7:0] data_mask = '0;
    logic [63:0] rd_data;
    logic rd_data_valid, init_calib, busy;
    int checks = 0, failures = 0;
    logic [63:0] ref_mem [D];
    logic [63:0] last_rd = '0;
    logic [63:0] got [4];
    logic [63:0] old2, old3;

    always #5 clk = ~clk;

    burst_ram #(
        .DEPTH_BITWIDTH(DW), .BURST_COUNT(4),
        .CYCLES_BEFORE_DATA_VALID(L), .CYCLES_BEFORE_INITIATED(N)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .cmd_en(cmd_en), .addr(addr),
        .wr_data(wr_data), .data_mask(data_mask), .rd_data(rd_data),
        .rd_data_valid(rd_data_valid), .init_calib(init_calib), .busy(busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs;
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_valid", {63'd0, rd_data_valid}, 64'd0);
        chk("rst_calib", {63'd0, init_calib}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd1);
    endtask

    task automatic recal;
        for (int i = 1; i < N; i++) begin
            step;
            chk("cal_calib", {63'd0, init_calib}, 64'd0);
            chk("cal_busy", {63'd0, busy}, 64'd1);
        end
        step;
        chk("cal_done_calib", {63'd0, init_calib}, 64'd1);
        chk("cal_done_busy", {63'd0, busy}, 64'd0);
    endtask

    task automatic wr_burst(input logic [DW-1:0] a, input logic [63:0] d0, input logic [63:0] d1,
                            input logic [63:0] d2, input logic [63:0] d3, input logic [7:0] m);
        logic [63:0] d [4];
        d = '{d0, d1, d2, d3};
        cmd_en = 1; cmd = 1; addr = a; data_mask = m;
        for (int k = 0; k < 4; k++) begin
            wr_data = d[k];
            step;
            cmd_en = 0;
            addr = DW'($urandom);
            ref_mem[(int'(a) + k) % D] = d[k];
            chk("wr_valid", {63'd0, rd_data_valid}, 64'd0);
            chk("wr_busy", {63'd0, busy}, (k < 3) ? 64'd1 : 64'd0);
        end
        wr_data = 64'($urandom);
    endtask

    task automatic rd_burst(input logic [DW-1:0] a, input bit inj);
        cmd_en = 1; cmd = 0; addr = a;
        step;
        cmd_en = 0;
        addr = DW'($urandom);
        chk("rd_accept_busy", {63'd0, busy}, 64'd1);
        for (int i = 1; i < L; i++) begin
            step;
            chk("rd_wait_valid", {63'd0, rd_data_valid}, 64'd0);
            chk("rd_wait_busy", {63'd0, busy}, 64'd1);
        end
        for (int k = 0; k < 4; k++) begin
            if (inj && k == 1) begin
                cmd_en = 1; cmd = 1; addr = 4'd8; wr_data = 64'hDEAD;
            end else cmd_en = 0;
            step;
            last_rd = ref_mem[(int'(a) + k) % D];
            got[k] = rd_data;
            chk("rd_beat_data", rd_data, last_rd);
            chk("rd_beat_valid", {63'd0, rd_data_valid}, 64'd1);
            chk("rd_beat_busy", {63'd0, busy}, 64'd1);
        end
        cmd_en = 0;
        step;
        chk("rd_end_valid", {63'd0, rd_data_valid}, 64'd0);
        chk("rd_end_busy", {63'd0, busy}, 64'd0);
        chk("rd_end_hold", rd_data, last_rd);
    endtask

    initial begin
        rst = 1;
        step;
        chk_reset_outputs;
        rst = 0;
        cmd_en = 1; cmd = 0; addr = 0;
        for (int i = 1; i <= 9; i++) begin
            step;
            chk("cal_early_calib", {63'd0, init_calib}, 64'd0);
            chk("cal_early_busy", {63'd0, busy}, 64'd1);
            chk("cal_early_valid", {63'd0, rd_data_valid}, 64'd0);
        end
        cmd_en = 0;
        step;
        chk("cal_e10_calib", {63'd0, init_calib}, 64'd1);
        chk("cal_e10_busy", {63'd0, busy}, 64'd0);
        wr_burst(0, 64'($urandom), 64'($urandom), 64'($urandom), 64'($urandom), 8'h00);
        wr_burst(8, 64'($urandom), 64'($urandom), 64'($urandom), 64'($urandom), 8'h00);
        wr_burst(12, 64'($urandom), 64'($urandom), 64'($urandom), 64'($urandom), 8'h00);
        wr_burst(4, 64'h1111_1111_0000_0000, 64'h2222_2222_0000_0000,
                 64'h3333_3333_0000_0000, 64'h4444_4444_0000_0000, 8'h00);
        rd_burst(4, 0);
        chk("wr_rd_b0", got[0], 64'h1111_1111_0000_0000);
        chk("wr_rd_b3", got[3], 64'h4444_4444_0000_0000);
        wr_burst(14, 64'hA0, 64'hA1, 64'hA2, 64'hA3, 8'h00);
        rd_burst(0, 0);
        chk("wrap_b0", got[0], 64'hA2);
        chk("wrap_b1", got[1], 64'hA3);
        old2 = ref_mem[8];
        rd_burst(4, 1);
        rd_burst(8, 0);
        chk("busy_ignored_mem8", got[0], old2);
        wr_burst(5, 64'h0123_4567_89AB_CDEF, 64'($urandom), 64'($urandom), 64'($urandom), 8'hFF);
        rd_burst(5, 0);
        chk("mask_ignored", got[0], 64'h0123_4567_89AB_CDEF);
        old2 = ref_mem[2];
        old3 = ref_mem[3];
        cmd_en = 1; cmd = 1; addr = 0; wr_data = 64'h10;
        step;
        ref_mem[0] = 64'h10;
        cmd_en = 0; wr_data = 64'h11;
        step;
        ref_mem[1] = 64'h11;
        wr_data = 64'h12; rst = 1;
        step;
        chk_reset_outputs;
        rst = 0;
        wr_data = 64'h13;
        last_rd = 0;
        recal;
        rd_burst(0, 0);
        chk("rstwr_b0", got[0], 64'h10);
        chk("rstwr_b1", got[1], 64'h11);
        chk("rstwr_b2", got[2], old2);
        chk("rstwr_b3", got[3], old3);
        repeat (30) begin
            repeat ($urandom_range(0, 3)) begin
                step;
                chk("idle_busy", {63'd0, busy}, 64'd0);
                chk("idle_valid", {63'd0, rd_data_valid}, 64'd0);
                chk("idle_hold", rd_data, last_rd);
            end
            if ($urandom_range(0, 1) == 1)
                wr_burst(DW'($urandom), 64'($urandom), {32'($urandom), 32'($urandom)},
                         64'($urandom), {32'($urandom), 32'($urandom)}, 8'($urandom));
            else
                rd_burst(DW'($urandom), bit'($urandom_range(0, 1)));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
